mem_stage: RTL and testbench

Memory-access stage of the five-stage integer pipeline, directly downstream of the execute stage. It accepts the execute result (write data, write address, write enable) plus a memory operation descriptor. It performs at most one outstanding load or store on a req/ack data bus, raising a stall request for as long as the bus is busy. The result is registered toward write-back.

---
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues at most one load/store on a req/ack bus,
// stalls upstream while the bus is busy, and registers the result toward write-back.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        ex_write_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_wdata_o,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_write_o,
  output logic        err_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_SW  = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        write_q, write_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic        wb_write_q, wb_write_d;
  logic        err_q, err_d;

  logic        is_mem, is_word, is_store, misaligned, timeout;
  logic [7:0]  rbyte;
  logic [31:0] load_data;

  always_comb begin
    is_mem     = (mem_op_i >= OP_LW) && (mem_op_i <= OP_SB);
    is_word    = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    is_store   = (mem_op_i == OP_SW) || (mem_op_i == OP_SB);
    misaligned = is_word && (mem_addr_i[1:0] != 2'b00);
    timeout    = (state_q == S_WAIT) && !bus_ack_i && (cnt_q == CNT_LAST);
  end

  // Little-endian byte pick for byte loads, using the lane latched at issue.
  always_comb begin
    rbyte = bus_rdata_i[8*lane_q +: 8];
    case (op_q)
      OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_data = {24'd0, rbyte};
      default: load_data = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    op_d        = op_q;
    lane_d      = lane_q;
    waddr_d     = waddr_q;
    write_d     = write_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    wb_valid_d  = 1'b0;
    wb_wdata_d  = wb_wdata_q;
    wb_waddr_d  = wb_waddr_q;
    wb_write_d  = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_wdata_d = ex_wdata_i;
            wb_waddr_d = ex_waddr_i;
            wb_write_d = ex_write_i;
          end else if (misaligned) begin
            wb_valid_d = 1'b1;
            wb_wdata_d = ex_wdata_i;
            wb_waddr_d = ex_waddr_i;
            err_d      = 1'b1;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = 8'd0;
            kill_d      = 1'b0;
            op_d        = mem_op_i;
            lane_d      = mem_addr_i[1:0];
            waddr_d     = ex_waddr_i;
            write_d     = ex_write_i;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {mem_addr_i[31:2], 2'b00};
            bus_be_d    = is_word ? 4'b1111 : (4'b0001 << mem_addr_i[1:0]);
            bus_wdata_d = (mem_op_i == OP_SB) ? {4{store_data_i[7:0]}} :
                          (mem_op_i == OP_SW) ? store_data_i : 32'd0;
          end
        end
      end
      S_WAIT: begin
        kill_d = kill_q || flush_i;
        if (bus_ack_i || timeout) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
          kill_d    = 1'b0;
          // A flush seen at any point of the access silences its completion.
          if (!(kill_q || flush_i)) begin
            wb_valid_d = 1'b1;
            wb_waddr_d = waddr_q;
            if (!bus_ack_i) begin
              err_d = 1'b1;
            end else if (op_q != OP_SW && op_q != OP_SB) begin
              wb_wdata_d = load_data;
              wb_write_d = write_q;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      kill_q      <= 1'b0;
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      waddr_q     <= 5'd0;
      write_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_wdata_q  <= 32'd0;
      wb_waddr_q  <= 5'd0;
      wb_write_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      waddr_q     <= waddr_d;
      write_q     <= write_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_write_q  <= wb_write_d;
      err_q       <= err_d;
    end
  end

  // Stall drops in the completing cycle so upstream advances on the same edge.
  assign stall_req_o = rst &&
      (((state_q == S_IDLE) && valid_i && is_mem && !misaligned && !flush_i) ||
       ((state_q == S_WAIT) && !bus_ack_i && !timeout));

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_wdata_o  = wb_wdata_q;
  assign wb_waddr_o  = wb_waddr_q;
  assign wb_write_o  = wb_write_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores push expected write-back
// records; a negedge monitor pops and compares whenever the stage emits a result.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ex_write_i, flush_i, bus_ack_i;
  logic [2:0]  mem_op_i;
  logic [31:0] mem_addr_i, store_data_i, ex_wdata_i, bus_rdata_i;
  logic [4:0]  ex_waddr_i;
  logic        stall_req_o, bus_req_o, bus_we_o, wb_valid_o, wb_write_o, err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wb_wdata_o;
  logic [3:0]  bus_be_o;
  logic [4:0]  wb_waddr_o;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .ex_wdata_i(ex_wdata_i), .ex_waddr_i(ex_waddr_i), .ex_write_i(ex_write_i),
    .flush_i(flush_i), .stall_req_o(stall_req_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .wb_valid_o(wb_valid_o), .wb_wdata_o(wb_wdata_o), .wb_waddr_o(wb_waddr_o),
    .wb_write_o(wb_write_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic        write;
    logic [4:0]  waddr;
    logic        chk;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic push(input logic err, input logic write, input logic [4:0] waddr,
                      input logic chk, input logic [31:0] wdata);
    exp_t e;
    e.err = err; e.write = write; e.waddr = waddr; e.chk = chk; e.wdata = wdata;
    sb_q.push_back(e);
  endtask

  // Each result is visible for exactly one cycle, so one negedge sees it once.
  always @(negedge clk) begin
    if (rst && (wb_valid_o || err_o)) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", {30'd0, wb_valid_o, err_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("wb_err",   {31'd0, err_o}, {31'd0, e.err});
        check("wb_write", {31'd0, wb_write_o}, {31'd0, e.write});
        check("wb_waddr", {27'd0, wb_waddr_o}, {27'd0, e.waddr});
        if (e.chk) check("wb_wdata", wb_wdata_o, e.wdata);
      end
    end
  end

  task automatic check_bus(input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic e_we, input logic [31:0] e_wdata);
    check("bus_req",  {31'd0, bus_req_o}, 32'd1);
    check("bus_addr", bus_addr_o, e_addr);
    check("bus_be",   {28'd0, bus_be_o}, {28'd0, e_be});
    check("bus_we",   {31'd0, bus_we_o}, {31'd0, e_we});
    if (e_we) check("bus_wdata", bus_wdata_o, e_wdata);
  endtask

  // Called just after a rising edge; ack arrives in WAIT cycle number ack_wait.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [4:0] waddr,
                               input logic wr, input int ack_wait,
                               input logic [31:0] rdata, input logic [31:0] e_addr,
                               input logic [3:0] e_be, input logic e_we,
                               input logic [31:0] e_wdata, input int flush_at);
    int stalls = 0;
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; store_data_i = sdata;
    ex_waddr_i = waddr; ex_write_i = wr; ex_wdata_i = 32'h5555_AAAA;
    @(negedge clk); if (stall_req_o) stalls++;
    @(posedge clk); #1;
    valid_i = 1'b0; mem_op_i = 3'd0;
    for (int i = 0; i < ack_wait; i++) begin
      flush_i = (i == flush_at);
      @(negedge clk);
      if (i == 0) check_bus(e_addr, e_be, e_we, e_wdata);
      if (stall_req_o) stalls++;
      @(posedge clk); #1;
    end
    flush_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = rdata;
    @(negedge clk);
    if (ack_wait == 0) check_bus(e_addr, e_be, e_we, e_wdata);
    if (stall_req_o) stalls++;
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    check("stall_cycles", stalls, ack_wait + 1);
    check("req_dropped", {31'd0, bus_req_o}, 32'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    valid_i = 1'b1; mem_op_i = 3'd1; mem_addr_i = 32'h0; store_data_i = 32'd0;
    ex_wdata_i = 32'd0; ex_waddr_i = 5'd0; ex_write_i = 1'b0;
    #3;
    check("rst_stall",    {31'd0, stall_req_o}, 32'd0);
    check("rst_bus_req",  {31'd0, bus_req_o}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_err",      {31'd0, err_o}, 32'd0);
    valid_i = 1'b0; mem_op_i = 3'd0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // ORI result passes straight through with no stall
    valid_i = 1'b1; mem_op_i = 3'd0; ex_wdata_i = 32'h0000_1234;
    ex_waddr_i = 5'd3; ex_write_i = 1'b1;
    push(1'b0, 1'b1, 5'd3, 1'b1, 32'h0000_1234);
    @(negedge clk); check("ori_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1; valid_i = 1'b0;
    @(posedge clk); #1;

    push(1'b0, 1'b1, 5'd5, 1'b1, 32'hFFFF_FF80);
    applyStimulus(3'd3, 32'h103, 32'd0, 5'd5, 1'b1, 3, 32'h80FF_0000,
                  32'h100, 4'b1000, 1'b0, 32'd0, -1);
    push(1'b0, 1'b1, 5'd6, 1'b1, 32'h0000_0080);
    applyStimulus(3'd4, 32'h103, 32'd0, 5'd6, 1'b1, 3, 32'h80FF_0000,
                  32'h100, 4'b1000, 1'b0, 32'd0, -1);
    push(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    applyStimulus(3'd5, 32'h201, 32'h1234_56AB, 5'd0, 1'b0, 0, 32'd0,
                  32'h200, 4'b0010, 1'b1, 32'hABAB_ABAB, -1);
    push(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    applyStimulus(3'd2, 32'h704, 32'hCAFE_F00D, 5'd0, 1'b0, 1, 32'd0,
                  32'h704, 4'b1111, 1'b1, 32'hCAFE_F00D, -1);

    // misaligned LW: error pulse, no bus access
    valid_i = 1'b1; mem_op_i = 3'd1; mem_addr_i = 32'h102; ex_waddr_i = 5'd9; ex_write_i = 1'b1;
    push(1'b1, 1'b0, 5'd9, 1'b0, 32'd0);
    @(negedge clk); check("mis_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1; valid_i = 1'b0; mem_op_i = 3'd0;
    @(negedge clk); check("mis_no_req", {31'd0, bus_req_o}, 32'd0);
    @(posedge clk); #1;

    // timeout with TIMEOUT=4
    valid_i = 1'b1; mem_op_i = 3'd1; mem_addr_i = 32'h300; ex_waddr_i = 5'd4; ex_write_i = 1'b1;
    push(1'b1, 1'b0, 5'd4, 1'b0, 32'd0);
    @(negedge clk); check("to_stall", {31'd0, stall_req_o}, 32'd1);
    @(posedge clk); #1; valid_i = 1'b0; mem_op_i = 3'd0;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (bus_req_o) cnt++; end
    check("to_req_cycles", cnt, 4);
    check("to_stall_released", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1;

    // flush during WAIT: access completes silently
    applyStimulus(3'd1, 32'h400, 32'd0, 5'd8, 1'b1, 2, 32'h1111_2222,
                  32'h400, 4'b1111, 1'b0, 32'd0, 1);
    @(posedge clk); #1;

    // reset dropped mid-WAIT
    valid_i = 1'b1; mem_op_i = 3'd1; mem_addr_i = 32'h500; ex_waddr_i = 5'd2;
    @(posedge clk); #1; valid_i = 1'b0; mem_op_i = 3'd0;
    @(negedge clk); check("pre_rst_req", {31'd0, bus_req_o}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_req",   {31'd0, bus_req_o}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    push(1'b0, 1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(3'd1, 32'h600, 32'd0, 5'd7, 1'b1, 1, 32'hDEAD_BEEF,
                  32'h600, 4'b1111, 1'b0, 32'd0, -1);
    repeat (3) @(posedge clk);
    #1 check("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
